// File: rtl/mcpu_mem_seq_if.sv
// mcpu_mem_seq_if: CPU-side request/done bus plus memory/IO bus of the access sequencer
interface mcpu_mem_seq_if #(parameter int ADDR_W = 32);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              done;
    logic              fault;
    logic [1:0]        fault_code;
    logic              busy;
    logic [ADDR_W-1:0] Addr_out;
    logic [31:0]       Data_out;
    logic [3:0]        byte_en;
    logic              mem_w;
    logic              CPU_MIO;
    logic [31:0]       Data_in;
    logic              MIO_ready;
    modport slave (
        input  req, we, size, sign_ext, addr, wdata, Data_in, MIO_ready,
        output rdata, done, fault, fault_code, busy, Addr_out, Data_out, byte_en, mem_w, CPU_MIO
    );
    modport master (
        output req, we, size, sign_ext, addr, wdata, Data_in, MIO_ready,
        input  rdata, done, fault, fault_code, busy, Addr_out, Data_out, byte_en, mem_w, CPU_MIO
    );
endinterface

// File: rtl/mcpu_mem_seq.sv
// mcpu_mem_seq: sized memory/IO access sequencer with wait states, timeout and fault reporting
module mcpu_mem_seq #(
    parameter int ADDR_W   = 32,
    parameter int MIN_WAIT = 0,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = 8
) (
    input logic           clk,
    input logic           reset,
    mcpu_mem_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        size_q, size_d, off_q, off_d, code_q, code_d;
    logic              sext_q, sext_d;
    logic [31:0]       rdata_q, rdata_d, dout_q, dout_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic              done_q, done_d, fault_q, fault_d, busy_q, busy_d;
    logic              mem_w_q, mem_w_d, mio_q, mio_d;
    logic              misal;
    logic [7:0]        rd_b;
    logic [15:0]       rd_h;
    logic [31:0]       rd_ext;
    assign misal  = (bus.size == 2'b01 && bus.addr[0]) || (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
    assign rd_b   = bus.Data_in[{off_q, 3'b000} +: 8];
    assign rd_h   = bus.Data_in[{off_q[1], 4'b0000} +: 16];
    assign rd_ext = size_q == 2'b00 ? {{24{sext_q & rd_b[7]}}, rd_b}
                  : size_q == 2'b01 ? {{16{sext_q & rd_h[15]}}, rd_h} : bus.Data_in;
    // next-state and next-output computation; done/fault are single-cycle pulses
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        off_d   = off_q;
        sext_d  = sext_q;
        code_d  = code_q;
        rdata_d = rdata_q;
        dout_d  = dout_q;
        addr_d  = addr_q;
        be_d    = be_q;
        busy_d  = busy_q;
        mem_w_d = mem_w_q;
        mio_d   = mio_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req && (bus.size == 2'b11 || misal)) begin
                    state_d = FAULT;
                    code_d  = bus.size == 2'b11 ? 2'b11 : 2'b01;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (bus.req) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(1);
                    size_d  = bus.size;
                    off_d   = bus.addr[1:0];
                    sext_d  = bus.sign_ext;
                    addr_d  = {bus.addr[ADDR_W-1:2], 2'b00};
                    dout_d  = bus.size == 2'b00 ? {4{bus.wdata[7:0]}}
                            : bus.size == 2'b01 ? {2{bus.wdata[15:0]}} : bus.wdata;
                    be_d    = bus.size == 2'b00 ? 4'b0001 << bus.addr[1:0]
                            : bus.size == 2'b01 ? 4'b0011 << bus.addr[1:0] : 4'b1111;
                    mem_w_d = bus.we;
                    mio_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ACCESS: begin
                if ((bus.MIO_ready && cnt_q > CNT_W'(MIN_WAIT)) || (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT))) begin
                    done_d  = 1'b1;
                    mio_d   = 1'b0;
                    mem_w_d = 1'b0;
                    dout_d  = '0;
                    be_d    = '0;
                end
                if (bus.MIO_ready && cnt_q > CNT_W'(MIN_WAIT)) begin
                    state_d = DONE;
                    rdata_d = mem_w_q ? rdata_q : rd_ext;
                end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = FAULT;
                    code_d  = 2'b10;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end
    // state and registered outputs, cleared by the active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            size_q  <= '0;
            off_q   <= '0;
            sext_q  <= 1'b0;
            code_q  <= '0;
            rdata_q <= '0;
            dout_q  <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
            mem_w_q <= 1'b0;
            mio_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            off_q   <= off_d;
            sext_q  <= sext_d;
            code_q  <= code_d;
            rdata_q <= rdata_d;
            dout_q  <= dout_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            busy_q  <= busy_d;
            mem_w_q <= mem_w_d;
            mio_q   <= mio_d;
        end
    end
    assign bus.rdata      = rdata_q;
    assign bus.done       = done_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
    assign bus.busy       = busy_q;
    assign bus.Addr_out   = addr_q;
    assign bus.Data_out   = dout_q;
    assign bus.byte_en    = be_q;
    assign bus.mem_w      = mem_w_q;
    assign bus.CPU_MIO    = mio_q;
endmodule

// File: tb/tb_mcpu_mem_seq.sv
// tb_mcpu_mem_seq: vector table, reset corner cases and random traffic against a reference model
module tb_mcpu_mem_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    logic req = 0, we = 0, sext = 0, rdy = 0;
    logic [1:0] size = 0;
    logic [31:0] addr = 0, wdata = 0, din = 0;
    int n_chk = 0, n_fail = 0;
    localparam int MW[2] = '{0, 2};
    localparam int TO[2] = '{16, 4};
    logic [31:0] exp_rd[2];
    logic [1:0] exp_code[2];
    mcpu_mem_seq_if #(.ADDR_W(32)) i0 ();
    mcpu_mem_seq_if #(.ADDR_W(32)) i1 ();
    mcpu_mem_seq #(.ADDR_W(32), .MIN_WAIT(0), .TIMEOUT(16), .CNT_W(8)) d0 (.clk(clk), .reset(reset), .bus(i0));
    mcpu_mem_seq #(.ADDR_W(32), .MIN_WAIT(2), .TIMEOUT(4), .CNT_W(8)) d1 (.clk(clk), .reset(reset), .bus(i1));
    assign i0.req = req;  assign i1.req = req;
    assign i0.we = we;    assign i1.we = we;
    assign i0.size = size; assign i1.size = size;
    assign i0.sign_ext = sext; assign i1.sign_ext = sext;
    assign i0.addr = addr; assign i1.addr = addr;
    assign i0.wdata = wdata; assign i1.wdata = wdata;
    assign i0.Data_in = din; assign i1.Data_in = din;
    assign i0.MIO_ready = rdy; assign i1.MIO_ready = rdy;
    logic [31:0] o_rdata[2], o_addr[2], o_dout[2];
    logic [3:0] o_be[2];
    logic [1:0] o_code[2];
    logic o_done[2], o_fault[2], o_busy[2], o_memw[2], o_mio[2];
    assign o_rdata[0] = i0.rdata;    assign o_rdata[1] = i1.rdata;
    assign o_addr[0] = i0.Addr_out;  assign o_addr[1] = i1.Addr_out;
    assign o_dout[0] = i0.Data_out;  assign o_dout[1] = i1.Data_out;
    assign o_be[0] = i0.byte_en;     assign o_be[1] = i1.byte_en;
    assign o_code[0] = i0.fault_code; assign o_code[1] = i1.fault_code;
    assign o_done[0] = i0.done;      assign o_done[1] = i1.done;
    assign o_fault[0] = i0.fault;    assign o_fault[1] = i1.fault;
    assign o_busy[0] = i0.busy;      assign o_busy[1] = i1.busy;
    assign o_memw[0] = i0.mem_w;     assign o_memw[1] = i1.mem_w;
    assign o_mio[0] = i0.CPU_MIO;    assign o_mio[1] = i1.CPU_MIO;

    typedef struct {
        logic we; logic [1:0] size; logic sext;
        logic [31:0] addr, wdata, din; int k;
        int e_dc; logic e_f; logic [1:0] e_c; logic [31:0] e_rd, e_dout; logic [3:0] e_be;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ext_ref(input logic [1:0] sz, input logic sx, input logic [1:0] a, input logic [31:0] d);
        int bits = 8 << sz;
        int sh = (sz == 0) ? 8 * int'(a) : (sz == 1) ? 16 * (int'(a) / 2) : 0;
        longint mask = (longint'(1) << bits) - 1;
        longint v = (longint'(d) >> sh) & mask;
        if (sx && bits < 32 && v[bits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] steer_ref(input logic [1:0] sz, input logic [31:0] w);
        return sz == 0 ? 32'(w[7:0]) * 32'h01010101 : sz == 1 ? 32'(w[15:0]) * 32'h00010001 : w;
    endfunction

    function automatic logic [3:0] be_ref(input logic [1:0] sz, input logic [1:0] a);
        return sz == 0 ? 4'(1 << a) : sz == 1 ? 4'(3 << a) : 4'hF;
    endfunction

    // access cycles n, done cycle (relative to the req cycle), fault flag and code
    task automatic model(input int mw, input int to, input logic [1:0] sz, input logic [31:0] a, input int k,
                         output int n, output int dc, output logic f, output logic [1:0] c);
        int s;
        n = 0; dc = 1; f = 1; c = 0;
        if (sz == 3) c = 3;
        else if ((sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)) c = 1;
        else begin
            s = (k + 1 > mw + 1) ? k + 1 : mw + 1;
            if (to != 0 && s > to) begin n = to; dc = to + 1; c = 2; end
            else begin n = s; dc = s + 1; f = 0; end
        end
    endtask

    task automatic run_txn(input logic t_we, input logic [1:0] t_size, input logic t_sext,
                           input logic [31:0] t_addr, input logic [31:0] t_wdata, input logic [31:0] t_din, input int t_k,
                           output int dc0, output logic f0, output logic [1:0] c0, output logic [31:0] rd0,
                           output logic [31:0] dout0, output logic [3:0] be0);
        int dcyc[2] = '{-1, -1};
        int ndone[2] = '{0, 0};
        int nacc[2] = '{0, 0};
        logic fl[2];
        logic [1:0] cd[2];
        logic [31:0] rdv[2], dov[2];
        logic [3:0] bev[2];
        int e_n, e_dc;
        logic e_f;
        logic [1:0] e_c;
        dov = '{0, 0};
        bev = '{0, 0};
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c > 0) begin
                for (int j = 0; j < 2; j++) begin
                    if (o_mio[j]) begin
                        nacc[j]++;
                        check($sformatf("d%0d Addr_out", j), o_addr[j], t_addr & ~32'd3);
                        check($sformatf("d%0d byte_en", j), 32'(o_be[j]), 32'(be_ref(t_size, t_addr[1:0])));
                        check($sformatf("d%0d mem_w", j), 32'(o_memw[j]), 32'(t_we));
                        if (t_we) check($sformatf("d%0d Data_out", j), o_dout[j], steer_ref(t_size, t_wdata));
                        dov[j] = o_dout[j];
                        bev[j] = o_be[j];
                    end
                    if (o_done[j]) begin
                        ndone[j]++;
                        if (dcyc[j] < 0) begin
                            dcyc[j] = c;
                            fl[j] = o_fault[j];
                            cd[j] = o_code[j];
                            rdv[j] = o_rdata[j];
                            check($sformatf("d%0d busy_at_done", j), 32'(o_busy[j]), 1);
                        end
                    end
                end
                if (dcyc[0] >= 0 && dcyc[1] >= 0) break;
            end
            req = (c == 0);
            we = t_we; size = t_size; sext = t_sext; addr = t_addr; wdata = t_wdata; din = t_din;
            rdy = (c > t_k);
        end
        for (int j = 0; j < 2; j++) begin
            model(MW[j], TO[j], t_size, t_addr, t_k, e_n, e_dc, e_f, e_c);
            if (e_f) exp_code[j] = e_c;
            else if (!t_we) exp_rd[j] = ext_ref(t_size, t_sext, t_addr[1:0], t_din);
            check($sformatf("d%0d done_cycle", j), 32'(dcyc[j]), 32'(e_dc));
            check($sformatf("d%0d done_count", j), 32'(ndone[j]), 1);
            check($sformatf("d%0d access_cycles", j), 32'(nacc[j]), 32'(e_n));
            check($sformatf("d%0d fault", j), 32'(fl[j]), 32'(e_f));
            check($sformatf("d%0d fault_code", j), 32'(cd[j]), 32'(exp_code[j]));
            check($sformatf("d%0d rdata", j), rdv[j], exp_rd[j]);
        end
        dc0 = dcyc[0]; f0 = fl[0]; c0 = cd[0]; rd0 = rdv[0]; dout0 = dov[0]; be0 = bev[0];
    endtask

    task automatic check_zero(input string tag);
        for (int j = 0; j < 2; j++) begin
            check($sformatf("d%0d %s rdata", j, tag), o_rdata[j], 0);
            check($sformatf("d%0d %s Addr_out", j, tag), o_addr[j], 0);
            check($sformatf("d%0d %s Data_out", j, tag), o_dout[j], 0);
            check($sformatf("d%0d %s flags", j, tag),
                  32'({o_done[j], o_fault[j], o_busy[j], o_memw[j], o_mio[j], o_be[j], o_code[j]}), 0);
        end
    endtask

    initial begin
        int dc;
        logic f;
        logic [1:0] c;
        logic [31:0] rd, dout;
        logic [3:0] be;
        tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0,  2,  1'b0, 2'd0, 32'hDEADBEEF, 32'h0, 4'hF};
        tbl[1]  = '{1'b1, 2'd0, 1'b0, 32'h203, 32'hA5, 32'h0, 0,        2,  1'b0, 2'd0, 32'hDEADBEEF, 32'hA5A5A5A5, 4'h8};
        tbl[2]  = '{1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'h80F07F01, 0,    2,  1'b0, 2'd0, 32'hFFFF80F0, 32'h0, 4'hC};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h1, 32'h0, 32'h80F07F01, 0,    2,  1'b0, 2'd0, 32'h0000007F, 32'h0, 4'h2};
        tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h12345678, 5,    7,  1'b0, 2'd0, 32'h12345678, 32'h0, 4'hF};
        tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 32'h0, 0,           1,  1'b1, 2'd1, 32'h12345678, 32'h0, 4'h0};
        tbl[6]  = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 0,           1,  1'b1, 2'd3, 32'h12345678, 32'h0, 4'h0};
        tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 30,         17, 1'b1, 2'd2, 32'h12345678, 32'h0, 4'hF};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 32'h3, 32'h0, 32'h85000000, 0,    2,  1'b0, 2'd2, 32'hFFFFFF85, 32'h0, 4'h8};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h0, 32'h1234ABCD, 32'h0, 0,    2,  1'b0, 2'd2, 32'hFFFFFF85, 32'hABCDABCD, 4'h3};
        tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h1, 32'h0, 32'h0, 0,           1,  1'b1, 2'd1, 32'hFFFFFF85, 32'h0, 4'h0};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 15,   17, 1'b0, 2'd1, 32'hCAFEF00D, 32'h0, 4'hF};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h0BADBEEF, 3,    5,  1'b0, 2'd1, 32'h0BADBEEF, 32'h0, 4'hF};
        exp_rd = '{0, 0};
        exp_code = '{0, 0};
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        for (int i = 0; i < 13; i++) begin
            run_txn(tbl[i].we, tbl[i].size, tbl[i].sext, tbl[i].addr, tbl[i].wdata, tbl[i].din, tbl[i].k, dc, f, c, rd, dout, be);
            check($sformatf("vec%0d done_cycle", i), 32'(dc), 32'(tbl[i].e_dc));
            check($sformatf("vec%0d fault", i), 32'(f), 32'(tbl[i].e_f));
            check($sformatf("vec%0d fault_code", i), 32'(c), 32'(tbl[i].e_c));
            check($sformatf("vec%0d rdata", i), rd, tbl[i].e_rd);
            if (tbl[i].e_dc > 1) check($sformatf("vec%0d byte_en", i), 32'(be), 32'(tbl[i].e_be));
            if (tbl[i].we) check($sformatf("vec%0d Data_out", i), dout, tbl[i].e_dout);
        end
        // reset in the second ACCESS cycle of a waiting read
        @(negedge clk);
        req = 1; we = 0; size = 2'd2; addr = 32'h40; rdy = 0; din = 32'h55AA55AA;
        @(negedge clk);
        req = 0;
        @(negedge clk);
        check("d0 mid_access CPU_MIO", 32'(o_mio[0]), 1);
        check("d1 mid_access CPU_MIO", 32'(o_mio[1]), 1);
        reset = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        reset = 1'b1;
        exp_rd = '{0, 0};
        exp_code = '{0, 0};
        run_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h55AA55AA, 0, dc, f, c, rd, dout, be);
        check("after_reset rdata", rd, 32'h55AA55AA);
        for (int i = 0; i < 150; i++) begin
            int k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(7, 20)) : int'($urandom_range(0, 6));
            run_txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom, $urandom, k,
                    dc, f, c, rd, dout, be);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
